// File: rtl/fsm_step_counter.sv
// Modulo-MODULO step counter: up/down by STEP, synchronous load with range check,
// optional Gray-coded output and registered wrap / load-error pulses.
module fsm_step_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULO  = 8,
    parameter int STEP    = 2,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             gray_sel,
    output logic [WIDTH-1:0] Salida,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH:0]   C_MOD  = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0]   C_STEP = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] C_RST  = WIDTH'(RST_VAL);

    if (WIDTH < 1 || MODULO < 2 || MODULO > (1 << WIDTH) ||
        STEP < 1 || STEP >= MODULO || RST_VAL < 0 || RST_VAL >= MODULO) begin : g_param_check
        $fatal(1, "fsm_step_counter: illegal parameter set");
    end

    logic [WIDTH-1:0] r_state;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_dn_wrap;
    logic [WIDTH-1:0] w_next_state;
    logic             w_next_wrap;
    logic             w_next_load_err;

    // One extra bit keeps state+STEP and state+MODULO from overflowing.
    assign w_ext     = {1'b0, r_state};
    assign w_up      = w_ext + C_STEP;
    assign w_dn_wrap = w_ext + C_MOD - C_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_RST;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wrap     <= w_next_wrap;
            r_load_err <= w_next_load_err;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_wrap     = 1'b0;
        w_next_load_err = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < C_MOD) begin
                w_next_state = load_val;
            end else begin
                w_next_state    = '0;
                w_next_load_err = 1'b1;
            end
        end else if (w_ext >= C_MOD) begin
            // Out-of-range state recovers to zero without signalling a wrap.
            w_next_state = '0;
        end else if (en) begin
            if (!dir) begin
                if (w_up >= C_MOD) begin
                    w_next_state = WIDTH'(w_up - C_MOD);
                    w_next_wrap  = 1'b1;
                end else begin
                    w_next_state = w_up[WIDTH-1:0];
                end
            end else begin
                if (w_ext >= C_STEP) begin
                    w_next_state = WIDTH'(w_ext - C_STEP);
                end else begin
                    w_next_state = w_dn_wrap[WIDTH-1:0];
                    w_next_wrap  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        Salida   = gray_sel ? (r_state ^ (r_state >> 1)) : r_state;
        wrap     = r_wrap;
        load_err = r_load_err;
    end

endmodule
